// File: rtl/render_scheduler_pkg.sv
// Shared definitions for the render scheduler slice.
//   FB_AW / FB_DW : framebuffer write-port address and data widths.
//   state_t       : scheduler FSM state type and its encodings.
//   id_width()    : width of a client index (at least one bit).
package render_scheduler_pkg;

    localparam int unsigned FB_AW = 19;
    localparam int unsigned FB_DW = 16;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StScan  = 3'd1;
    localparam state_t StStart = 3'd2;
    localparam state_t StRun   = 3'd3;
    localparam state_t StNext  = 3'd4;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_port_mux.sv
// Registered N-to-1 framebuffer write-port selector.
//   clk, rstn          : clock, asynchronous active-low reset
//   en                 : forward the selected client's bus this cycle
//   sel                : index of the selected client
//   cli_addr/data/wr   : packed client write buses, client i in slice i
//   fb_addr/data/wr    : registered framebuffer write port (1-cycle latency)
// Address and data only load on a forwarded write, so they hold their last
// value whenever fb_wr is low.
module fb_port_mux
    import render_scheduler_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned ID_W      = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic [ID_W-1:0]            sel,
    input  logic [N_CLIENTS*FB_AW-1:0] cli_addr,
    input  logic [N_CLIENTS*FB_DW-1:0] cli_data,
    input  logic [N_CLIENTS-1:0]       cli_wr,
    output logic [FB_AW-1:0]           fb_addr,
    output logic [FB_DW-1:0]           fb_data,
    output logic                       fb_wr
);

    logic [FB_AW-1:0] sel_addr;
    logic [FB_DW-1:0] sel_data;
    logic             sel_wr;

    logic [FB_AW-1:0] fb_addr_q;
    logic [FB_DW-1:0] fb_data_q;
    logic             fb_wr_q;

    // An out-of-range sel (non power-of-two client count) selects nothing.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < int'(N_CLIENTS); i++) begin
            if (sel == ID_W'(i)) begin
                sel_addr = cli_addr[i*FB_AW +: FB_AW];
                sel_data = cli_data[i*FB_DW +: FB_DW];
                sel_wr   = cli_wr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fb_addr_q <= '0;
            fb_data_q <= '0;
            fb_wr_q   <= 1'b0;
        end else begin
            fb_wr_q <= en & sel_wr;
            if (en && sel_wr) begin
                fb_addr_q <= sel_addr;
                fb_data_q <= sel_data;
            end
        end
    end

    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign fb_wr   = fb_wr_q;

endmodule

// File: rtl/render_scheduler.sv
// Per-frame render pass sequencer and framebuffer write-port owner.
//   clk, rstn        : clock, asynchronous active-low reset
//   frame_tick       : one pulse per frame; latches dirty when idle
//   dirty            : per-client redraw request (level)
//   start / done     : per-client pass handshake (one-cycle pulses)
//   cli_addr/data/wr : packed client write buses
//   fb_addr/data/wr  : framebuffer write port, only the active client reaches it
//   busy             : high from frame latch until the last pass ends
//   active_id        : current or last-scanned client index
//   frame_overrun    : pulse when a frame_tick arrives while busy
//   timeout_err      : sticky per-client watchdog abort flags
// Clients run one at a time in index order; each pass is bounded by a
// watchdog of TIMEOUT cycles.
module render_scheduler
    import render_scheduler_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned TIMEOUT   = 1048576,
    parameter int unsigned TO_W      = 21,
    localparam int unsigned ID_W     = id_width(N_CLIENTS)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       frame_tick,
    input  logic [N_CLIENTS-1:0]       dirty,
    output logic [N_CLIENTS-1:0]       start,
    input  logic [N_CLIENTS-1:0]       done,
    input  logic [N_CLIENTS*FB_AW-1:0] cli_addr,
    input  logic [N_CLIENTS*FB_DW-1:0] cli_data,
    input  logic [N_CLIENTS-1:0]       cli_wr,
    output logic [FB_AW-1:0]           fb_addr,
    output logic [FB_DW-1:0]           fb_data,
    output logic                       fb_wr,
    output logic                       busy,
    output logic [ID_W-1:0]            active_id,
    output logic                       frame_overrun,
    output logic [N_CLIENTS-1:0]       timeout_err
);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        idx_q, idx_d;
    logic [N_CLIENTS-1:0]   pending_q, pending_d;
    logic [TO_W-1:0]        wd_q, wd_d;
    logic                   busy_q, busy_d;
    logic [ID_W-1:0]        active_id_q, active_id_d;
    logic [N_CLIENTS-1:0]   start_q, start_d;
    logic                   overrun_q, overrun_d;
    logic [N_CLIENTS-1:0]   timeout_q, timeout_d;

    logic last_client;
    logic wd_expired;

    assign last_client = (idx_q == ID_W'(N_CLIENTS - 1));
    assign wd_expired  = (wd_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        wd_d        = wd_q;
        busy_d      = busy_q;
        active_id_d = active_id_q;
        start_d     = '0;
        timeout_d   = timeout_q;
        // A tick that lands while busy is dropped and only reported.
        overrun_d   = frame_tick & busy_q;

        unique case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    pending_d = dirty;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StScan;
                end
            end
            StScan: begin
                active_id_d = idx_q;
                if (pending_q[idx_q]) begin
                    state_d = StStart;
                end else if (last_client) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + ID_W'(1);
                end
            end
            StStart: begin
                start_d[idx_q] = 1'b1;
                wd_d           = '0;
                state_d        = StRun;
            end
            StRun: begin
                wd_d = wd_q + TO_W'(1);
                // done takes priority over a coincident watchdog expiry.
                if (done[idx_q]) begin
                    pending_d[idx_q] = 1'b0;
                    state_d          = StNext;
                end else if (wd_expired) begin
                    timeout_d[idx_q] = 1'b1;
                    pending_d[idx_q] = 1'b0;
                    state_d          = StNext;
                end
            end
            StNext: begin
                if (last_client) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + ID_W'(1);
                    state_d = StScan;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pending_q   <= '0;
            wd_q        <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
            start_q     <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
            start_q     <= start_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    // Only RUN forwards, so writes outside a pass or from other clients are lost.
    fb_port_mux #(
        .N_CLIENTS (N_CLIENTS),
        .ID_W      (ID_W)
    ) u_fb_port_mux (
        .clk      (clk),
        .rstn     (rstn),
        .en       (state_q == StRun),
        .sel      (idx_q),
        .cli_addr (cli_addr),
        .cli_data (cli_data),
        .cli_wr   (cli_wr),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_wr    (fb_wr)
    );

    assign start         = start_q;
    assign busy          = busy_q;
    assign active_id     = active_id_q;
    assign frame_overrun = overrun_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_render_scheduler.sv
// Scoreboard bench for render_scheduler: stimulus pushes expected start
// pulses, framebuffer writes and overrun pulses (with their cycle numbers)
// into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_render_scheduler;

    localparam int NC = 4;

    typedef struct {
        int idx;
        int cyc;
    } start_exp_t;

    typedef struct {
        logic [18:0] addr;
        logic [15:0] data;
        int          cyc;
    } fb_exp_t;

    logic             clk;
    logic             rstn;
    logic             frame_tick;
    logic [NC-1:0]    dirty;
    logic [NC-1:0]    start;
    logic [NC-1:0]    done;
    logic [NC*19-1:0] cli_addr;
    logic [NC*16-1:0] cli_data;
    logic [NC-1:0]    cli_wr;
    logic [18:0]      fb_addr;
    logic [15:0]      fb_data;
    logic             fb_wr;
    logic             busy;
    logic [1:0]       active_id;
    logic             frame_overrun;
    logic [NC-1:0]    timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    start_exp_t exp_start[$];
    fb_exp_t    exp_fb[$];
    int         exp_ovr[$];

    render_scheduler #(
        .N_CLIENTS (NC),
        .TIMEOUT   (16),
        .TO_W      (5)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .frame_tick    (frame_tick),
        .dirty         (dirty),
        .start         (start),
        .done          (done),
        .cli_addr      (cli_addr),
        .cli_data      (cli_data),
        .cli_wr        (cli_wr),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_wr         (fb_wr),
        .busy          (busy),
        .active_id     (active_id),
        .frame_overrun (frame_overrun),
        .timeout_err   (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

    // Monitor: every presented output must match the head of its queue.
    always @(negedge clk) begin
        start_exp_t es;
        fb_exp_t    ef;
        int         eo;
        if (rstn) begin
            if (start != '0) begin
                checks++;
                if (exp_start.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected: got start=%b at cycle %0d expected none",
                             start, cyc);
                end else begin
                    es = exp_start.pop_front();
                    if (start !== 4'(1 << es.idx) || cyc != es.cyc) begin
                        errors++;
                        $display("FAIL start_pulse: got %b at cycle %0d expected %b at cycle %0d",
                                 start, cyc, 4'(1 << es.idx), es.cyc);
                    end
                end
            end
            if (fb_wr) begin
                checks++;
                if (exp_fb.size() == 0) begin
                    errors++;
                    $display("FAIL fb_unexpected: got addr=%h data=%h at cycle %0d expected none",
                             fb_addr, fb_data, cyc);
                end else begin
                    ef = exp_fb.pop_front();
                    if (fb_addr !== ef.addr || fb_data !== ef.data || cyc != ef.cyc) begin
                        errors++;
                        $display("FAIL fb_write: got %h/%h at cycle %0d expected %h/%h at cycle %0d",
                                 fb_addr, fb_data, cyc, ef.addr, ef.data, ef.cyc);
                    end
                end
            end
            if (frame_overrun) begin
                checks++;
                if (exp_ovr.size() == 0) begin
                    errors++;
                    $display("FAIL overrun_unexpected: got pulse at cycle %0d expected none", cyc);
                end else begin
                    eo = exp_ovr.pop_front();
                    if (cyc != eo) begin
                        errors++;
                        $display("FAIL overrun_pulse: got cycle %0d expected cycle %0d", cyc, eo);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cli(input int i, input logic [18:0] a, input logic [15:0] d,
                           input logic w);
        cli_addr[i*19 +: 19] = a;
        cli_data[i*16 +: 16] = d;
        cli_wr[i]            = w;
    endtask

    task automatic pulse_tick(input logic [NC-1:0] d, input int start_idx, input int lat);
        step();
        dirty      = d;
        frame_tick = 1'b1;
        if (start_idx >= 0) exp_start.push_back('{idx: start_idx, cyc: cyc + lat});
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_start(input int i);
        bit seen = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (start[i]) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_start%0d: got no pulse expected pulse within 64 cycles", i);
        end
    endtask

    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got busy=1 expected busy=0 within 64 cycles", name);
        end
    endtask

    initial begin
        int busy_cnt;
        rstn       = 1'b1;
        frame_tick = 1'b0;
        dirty      = '0;
        done       = '0;
        cli_addr   = '0;
        cli_data   = '0;
        cli_wr     = '0;
        #2 rstn = 1'b0;
        #1;
        check("rst_start", 64'(start), 0);
        check("rst_fb_wr", 64'(fb_wr), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_timeout_err", 64'(timeout_err), 0);
        step();
        step();
        rstn = 1'b1;

        // Dirty 0101: clients 0 and 2 run; a foreign write and done from
        // client 2 during client 0's pass must be ignored.
        pulse_tick(4'b0101, 0, 3);
        wait_start(0);
        step();
        set_cli(2, 19'h12345, 16'hAAAA, 1'b1);
        done[2] = 1'b1;
        step();
        set_cli(2, 19'h0, 16'h0, 1'b0);
        done[2] = 1'b0;
        set_cli(0, 19'h00100, 16'hF800, 1'b1);
        exp_fb.push_back('{addr: 19'h00100, data: 16'hF800, cyc: cyc + 1});
        step();
        set_cli(0, 19'h0, 16'h0, 1'b0);
        done[0] = 1'b1;
        exp_start.push_back('{idx: 2, cyc: cyc + 5});
        step();
        done[0] = 1'b0;
        wait_start(2);
        step();
        // Write in the done cycle is still forwarded.
        set_cli(2, 19'h00200, 16'h07E0, 1'b1);
        done[2] = 1'b1;
        exp_fb.push_back('{addr: 19'h00200, data: 16'h07E0, cyc: cyc + 1});
        step();
        set_cli(2, 19'h0, 16'h0, 1'b0);
        done[2] = 1'b0;
        @(negedge clk);
        check("t1_busy_next", 64'(busy), 1);
        @(negedge clk);
        check("t1_busy_scan3", 64'(busy), 1);
        @(negedge clk);
        check("t1_busy_fall", 64'(busy), 0);
        check("t1_active_id", 64'(active_id), 3);
        check("t1_fb_hold_addr", 64'(fb_addr), 64'h00200);

        // Empty frame: four SCAN cycles of busy, nothing else.
        pulse_tick(4'b0000, -1, 0);
        busy_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("t2_busy_cycles", 64'(busy_cnt), 4);

        // Client 1 hangs: aborted after 16 RUN cycles.
        pulse_tick(4'b0010, 1, 4);
        wait_start(1);
        repeat (15) @(negedge clk);
        check("t3_no_err_yet", 64'(timeout_err), 0);
        @(negedge clk);
        check("t3_timeout_err", 64'(timeout_err), 64'b0010);
        repeat (2) @(negedge clk);
        check("t3_busy_tail", 64'(busy), 1);
        @(negedge clk);
        check("t3_busy_fall", 64'(busy), 0);
        pulse_tick(4'b0001, 0, 3);
        wait_start(0);
        step();
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;
        wait_idle("t3_good_frame_idle");
        check("t3_err_sticky", 64'(timeout_err), 64'b0010);

        // Tick while busy: overrun pulse, no relatch of the new dirty set.
        pulse_tick(4'b0001, 0, 3);
        wait_start(0);
        step();
        dirty      = 4'b1111;
        frame_tick = 1'b1;
        exp_ovr.push_back(cyc + 1);
        step();
        frame_tick = 1'b0;
        step();
        step();
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;
        dirty   = '0;
        wait_idle("t4_idle");
        repeat (4) @(negedge clk);
        check("t4_still_idle", 64'(busy), 0);

        // Reset mid-RUN while fb_wr is high.
        pulse_tick(4'b0001, 0, 3);
        wait_start(0);
        step();
        set_cli(0, 19'h7FFFF, 16'hFFFF, 1'b1);
        exp_fb.push_back('{addr: 19'h7FFFF, data: 16'hFFFF, cyc: cyc + 1});
        step();
        set_cli(0, 19'h0, 16'h0, 1'b0);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("t6_start", 64'(start), 0);
        check("t6_fb_addr", 64'(fb_addr), 0);
        check("t6_fb_data", 64'(fb_data), 0);
        check("t6_fb_wr", 64'(fb_wr), 0);
        check("t6_busy", 64'(busy), 0);
        check("t6_active_id", 64'(active_id), 0);
        check("t6_overrun", 64'(frame_overrun), 0);
        check("t6_timeout_err", 64'(timeout_err), 0);
        step();
        step();
        rstn = 1'b1;
        pulse_tick(4'b0100, 2, 5);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t6_rescan_id", 64'(active_id), 1);
        wait_start(2);
        step();
        done[2] = 1'b1;
        step();
        done[2] = 1'b0;
        wait_idle("t6_idle");

        check("sb_start_empty", 64'(exp_start.size()), 0);
        check("sb_fb_empty", 64'(exp_fb.size()), 0);
        check("sb_ovr_empty", 64'(exp_ovr.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
